// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: input register, align, add, then
// normalize/round/pack into the output register. One global stall enable holds every stage.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   number1,
    input  logic [EXP_W+MAN_W:0]   number2,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_underflow
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;  // hidden + fraction + guard, round, sticky
    localparam int LZW = $clog2(SW + 1);
    localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam int MRW = MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0: operand capture
    logic         v0, op0;
    logic [W-1:0] a0, b0;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0  <= 1'b0;
            op0 <= 1'b0;
            a0  <= '0;
            b0  <= '0;
        end else if (adv) begin
            v0  <= in_valid;
            op0 <= op;
            a0  <= number1;
            b0  <= number2;
        end
    end

    // Stage 1: decode, specials, magnitude compare, alignment
    logic             sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, a_big, eff_sub, sign_l;
    logic [EXP_W-1:0] ea, eb, el, es, diff;
    logic [W-2:0]     mag_a, mag_b;
    logic [SW-1:0]    sig_a, sig_b, sig_l, sig_s, sig_sh, sig_al;
    logic             spec, spec_inv;
    logic [W-1:0]     spec_res;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sa      = a0[W-1];
        sb      = b0[W-1] ^ op0;
        ea      = a0[W-2:MAN_W];
        eb      = b0[W-2:MAN_W];
        za      = (ea == '0);
        zb      = (eb == '0);
        nan_a   = (ea == EXP_ONES) && (a0[MAN_W-1:0] != '0);
        nan_b   = (eb == EXP_ONES) && (b0[MAN_W-1:0] != '0);
        inf_a   = (ea == EXP_ONES) && (a0[MAN_W-1:0] == '0);
        inf_b   = (eb == EXP_ONES) && (b0[MAN_W-1:0] == '0);
        eff_sub = sa ^ sb;
        mag_a   = za ? '0 : a0[W-2:0];
        mag_b   = zb ? '0 : b0[W-2:0];
        sig_a   = za ? '0 : {1'b1, a0[MAN_W-1:0], 3'b000};
        sig_b   = zb ? '0 : {1'b1, b0[MAN_W-1:0], 3'b000};
        a_big   = (mag_a >= mag_b);
        sign_l  = a_big ? sa : sb;
        el      = a_big ? ea : eb;
        es      = a_big ? eb : ea;
        sig_l   = a_big ? sig_a : sig_b;
        sig_s   = a_big ? sig_b : sig_a;
        diff    = el - es;
        sig_sh  = sig_s >> diff;
        if (32'(diff) >= MAN_W + 3)
            sig_al = {{(SW-1){1'b0}}, |sig_s};
        else
            sig_al = sig_sh | SW'((sig_sh << diff) != sig_s);

        spec     = 1'b0;
        spec_inv = 1'b0;
        spec_res = '0;
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            spec     = 1'b1;
            spec_inv = 1'b1;
            spec_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (inf_a) begin
            spec     = 1'b1;
            spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf_b) begin
            spec     = 1'b1;
            spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             v1, spec1, inv1, sign1, sub1;
    logic [W-1:0]     sres1;
    logic [EXP_W-1:0] exp1;
    logic [SW-1:0]    sigl1, sigs1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; spec1 <= 1'b0; inv1 <= 1'b0; sign1 <= 1'b0; sub1 <= 1'b0;
            sres1 <= '0; exp1 <= '0; sigl1 <= '0; sigs1 <= '0;
        end else if (adv) begin
            v1 <= v0; spec1 <= spec; inv1 <= spec_inv; sign1 <= sign_l; sub1 <= eff_sub;
            sres1 <= spec_res; exp1 <= el; sigl1 <= sig_l; sigs1 <= sig_al;
        end
    end

    // Stage 2: significand add/subtract; L >= S so the difference is never negative
    logic [SW:0] sum;
    assign sum = sub1 ? ({1'b0, sigl1} - {1'b0, sigs1}) : ({1'b0, sigl1} + {1'b0, sigs1});

    logic             v2, spec2, inv2, sign2, sub2;
    logic [W-1:0]     sres2;
    logic [EXP_W-1:0] exp2;
    logic [SW:0]      sum2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0; spec2 <= 1'b0; inv2 <= 1'b0; sign2 <= 1'b0; sub2 <= 1'b0;
            sres2 <= '0; exp2 <= '0; sum2 <= '0;
        end else if (adv) begin
            v2 <= v1; spec2 <= spec1; inv2 <= inv1; sign2 <= sign1; sub2 <= sub1;
            sres2 <= sres1; exp2 <= exp1; sum2 <= sum;
        end
    end

    // Stage 3: normalize, round to nearest even, range check, pack
    logic [LZW-1:0]   lzc;
    logic [SW-1:0]    norm;
    logic [XW-1:0]    ex;
    logic             rnd, of_n, uf_n;
    logic [MRW-1:0]   mr;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     res_n;

    always_comb begin
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (sum2[i]) lzc = LZW'(SW - 1 - i);
        if (sum2[SW]) begin
            norm = sum2[SW:1] | SW'(sum2[0]);
            ex   = XW'(exp2) + XW'(1);
        end else begin
            norm = sum2[SW-1:0] << lzc;
            ex   = XW'(exp2) - XW'(lzc);
        end
        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr   = {1'b0, norm[SW-1:3]} + MRW'(rnd);
        frac = mr[MAN_W-1:0];
        if (mr[MAN_W+1]) begin
            frac = mr[MAN_W:1];
            ex   = ex + XW'(1);
        end
        of_n = 1'b0;
        uf_n = 1'b0;
        if (sum2 == '0) begin
            // exact cancellation gives +0; like-signed zeros keep their sign
            res_n = {sign2 & !sub2, {(W-1){1'b0}}};
        end else if (ex[XW-1] || ex == '0) begin
            res_n = {sign2, {(W-1){1'b0}}};
            uf_n  = 1'b1;
        end else if (ex >= XW'(EXP_ONES)) begin
            res_n = {sign2, EXP_ONES, {MAN_W{1'b0}}};
            of_n  = 1'b1;
        end else begin
            res_n = {sign2, ex[EXP_W-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; result <= '0;
            flag_invalid <= 1'b0; flag_overflow <= 1'b0; flag_underflow <= 1'b0;
        end else if (adv) begin
            out_valid      <= v2;
            result         <= !v2 ? '0 : (spec2 ? sres2 : res_n);
            flag_invalid   <= v2 && spec2 && inv2;
            flag_overflow  <= v2 && !spec2 && of_n;
            flag_underflow <= v2 && !spec2 && uf_n;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: single and half precision instances checked against a
// real-arithmetic reference model with explicit repacking to the target format.
module tb_fp_addsub_pipe;
    localparam int EW = 8, MW = 23, W = 32;
    localparam int HEW = 5, HMW = 10, HW = 16;

    typedef struct packed {
        logic [63:0] res;
        logic [2:0]  flags;  // {invalid, overflow, underflow}
    } exp_t;

    typedef struct packed {
        logic [31:0] a, b;
        logic        o;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, op, out_valid, out_ready, fi, fo, fu;
    logic [W-1:0]  n1, n2, res;
    logic          h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready, h_fi, h_fo, h_fu;
    logic [HW-1:0] h_n1, h_n2, h_res;

    fp_addsub_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .number1(n1), .number2(n2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(res), .flag_invalid(fi), .flag_overflow(fo), .flag_underflow(fu));

    fp_addsub_pipe #(.EXP_W(HEW), .MAN_W(HMW)) dut_half (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .number1(h_n1), .number2(h_n2), .op(h_op), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .result(h_res), .flag_invalid(h_fi),
        .flag_overflow(h_fo), .flag_underflow(h_fu));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t hq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic real to_real(logic s, logic [63:0] e, logic [63:0] f, int ew, int mw);
        logic [10:0] de;
        logic [51:0] df;
        longint      bias;
        bias = (longint'(1) << (ew - 1)) - 1;
        if (e == 64'd0) return $bitstoreal({s, 63'd0});
        de = 11'(longint'(e) - bias + 1023);
        df = 52'(f << (52 - mw));
        return $bitstoreal({s, de, df});
    endfunction

    // Round a double to mw fraction bits (RNE, unbounded exponent), then range-check.
    function automatic exp_t from_real(real r, int ew, int mw);
        exp_t        e;
        logic [63:0] d, sig, qv, rem, half, sgn, mmask;
        longint      ex, bx, emax, bias;
        int          sh;
        d     = $realtobits(r);
        mmask = (64'd1 << mw) - 64'd1;
        sgn   = {63'd0, d[63]} << (ew + mw);
        emax  = (longint'(1) << ew) - 1;
        bias  = (longint'(1) << (ew - 1)) - 1;
        e     = '0;
        if (d[62:52] == 11'd0) begin
            e.res = sgn;
            return e;
        end
        sh   = 52 - mw;
        sig  = {11'd0, 1'b1, d[51:0]};
        qv   = sig >> sh;
        rem  = sig & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && qv[0])) qv = qv + 64'd1;
        ex = longint'(d[62:52]) - 1023;
        if (qv == (64'd1 << (mw + 1))) begin
            qv = qv >> 1;
            ex++;
        end
        bx = ex + bias;
        if (bx >= emax) begin
            e.res   = sgn | (64'(emax) << mw);
            e.flags = 3'b010;
        end else if (bx <= 0) begin
            e.res   = sgn;
            e.flags = 3'b001;
        end else begin
            e.res = sgn | (64'(bx) << mw) | (qv & mmask);
        end
        return e;
    endfunction

    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic o, int ew, int mw);
        exp_t        e;
        logic        sa, sb, nan_a, nan_b, inf_a, inf_b;
        logic [63:0] ea, eb, fa, fb, emask, mmask, inf_bits;
        mmask    = (64'd1 << mw) - 64'd1;
        emask    = (64'd1 << ew) - 64'd1;
        sa       = a[ew+mw];
        sb       = b[ew+mw] ^ o;
        ea       = (a >> mw) & emask;
        eb       = (b >> mw) & emask;
        fa       = a & mmask;
        fb       = b & mmask;
        nan_a    = (ea == emask) && (fa != 0);
        nan_b    = (eb == emask) && (fb != 0);
        inf_a    = (ea == emask) && (fa == 0);
        inf_b    = (eb == emask) && (fb == 0);
        inf_bits = emask << mw;
        e        = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            e.res   = inf_bits | (64'd1 << (mw - 1));
            e.flags = 3'b100;
            return e;
        end
        if (inf_a) begin
            e.res = ({63'd0, sa} << (ew + mw)) | inf_bits;
            return e;
        end
        if (inf_b) begin
            e.res = ({63'd0, sb} << (ew + mw)) | inf_bits;
            return e;
        end
        return from_real(to_real(sa, ea, fa, ew, mw) + to_real(sb, eb, fb, ew, mw), ew, mw);
    endfunction

    // Compare process: inputs change just after posedge, so negedge sees the handshake
    // exactly as the next edge will.
    logic         held_v = 1'b0;
    logic [W-1:0] held_res;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hq.delete();
            held_v = 1'b0;
        end else begin
            check("in_ready_tracks_adv", 64'(in_ready), 64'(!out_valid || out_ready));
            if (in_valid && in_ready) q.push_back(model(64'(n1), 64'(n2), op, EW, MW));
            if (h_in_valid && h_in_ready) hq.push_back(model(64'(h_n1), 64'(h_n2), h_op, HEW, HMW));
            if (out_valid) begin
                if (held_v) check("stall_hold", 64'(res), 64'(held_res));
                if (out_ready) begin
                    check("output_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        check("result", 64'(res), q[0].res);
                        check("flags", 64'({fi, fo, fu}), 64'(q[0].flags));
                        void'(q.pop_front());
                    end
                end
                held_v   = !out_ready;
                held_res = res;
            end else begin
                held_v = 1'b0;
                check("idle_flags", 64'({fi, fo, fu}), 64'd0);
            end
            if (h_out_valid && h_out_ready) begin
                check("half_output_expected", 64'(hq.size() != 0), 64'd1);
                if (hq.size() != 0) begin
                    check("half_result", 64'(h_res), hq[0].res);
                    check("half_flags", 64'({h_fi, h_fo, h_fu}), 64'(hq[0].flags));
                    void'(hq.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o);
        int guard = 0;
        in_valid = 1'b1; n1 = a; n2 = b; op = o;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t vecs [16];
    exp_t e;
    int   lat;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; n1 = '0; n2 = '0; op = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_n1 = '0; h_n2 = '0; h_op = 1'b0; h_out_ready = 1'b1;

        vecs = '{
            '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},
            '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
            '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},
            '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},
            '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000},
            '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010},
            '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001},
            '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100},
            '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
            '{32'h00000000, 32'hC0A00000, 1'b0, 32'hC0A00000, 3'b000},
            '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},
            '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000},
            '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000},
            '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000},
            '{32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 3'b000}
        };

        // Pin the reference model to hand-computed results
        for (int i = 0; i < 16; i++) begin
            e = model(64'(vecs[i].a), 64'(vecs[i].b), vecs[i].o, EW, MW);
            check($sformatf("model_res_%0d", i), e.res, 64'(vecs[i].r));
            check($sformatf("model_flags_%0d", i), 64'(e.flags), 64'(vecs[i].f));
        end
        e = model(64'h3C00, 64'h3C00, 1'b0, HEW, HMW);
        check("model_half_add", e.res, 64'h4000);
        e = model(64'h3C00, 64'h4000, 1'b1, HEW, HMW);
        check("model_half_sub", e.res, 64'hBC00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(res), 64'd0);
        check("reset_flags", 64'({fi, fo, fu}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and basic add
        in_valid = 1'b1; n1 = 32'h3F800000; n2 = 32'h40000000; op = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        check("basic_add", 64'(res), 64'h40400000);
        check("basic_flags", 64'({fi, fo, fu}), 64'd0);

        // Directed vectors streamed back to back
        for (int i = 0; i < 16; i++) send(vecs[i].a, vecs[i].b, vecs[i].o);

        // Half precision instance
        h_in_valid = 1'b1; h_n1 = 16'h3C00; h_n2 = 16'h3C00; h_op = 1'b0;
        @(posedge clk); #1;
        h_n2 = 16'h4000; h_op = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;

        // Backpressure: out_ready pattern 1,0,0,1 while streaming 8 pairs
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h3F800000 + 32'(i) * 32'h00123457, 32'h40100000 - 32'(i) * 32'h0009A001,
                         1'(i % 2));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        for (int c = 0; c < 50 && (q.size() != 0 || hq.size() != 0); c++) @(posedge clk);
        #1;
        check("drain_main", 64'(q.size()), 64'd0);
        check("drain_half", 64'(hq.size()), 64'd0);

        // Reset with three operations in flight
        @(posedge clk); #1;
        send(32'h3F800000, 32'h3F800000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_result", 64'(res), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("no_stale_output", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
